// File: rtl/smi_rx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | smi_rx_scheduler: round-robin burst reader of the 09/24 RX FIFOs onto the   |
// | SMI byte stream, plus per-channel overflow counters.       Rev 1.0         |
// +-----------------------------------------------------------------------------+
module smi_rx_scheduler #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic        i_sys_clk,
    input  logic        i_rst_b,
    input  logic [1:0]  i_ch_en,
    output logic        o_fifo_09_pull,
    input  logic [31:0] i_fifo_09_data,
    input  logic        i_fifo_09_empty,
    input  logic        i_fifo_09_full,
    output logic        o_fifo_24_pull,
    input  logic [31:0] i_fifo_24_data,
    input  logic        i_fifo_24_empty,
    input  logic        i_fifo_24_full,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    output logic        o_byte_ch,
    output logic        o_byte_sow,
    output logic [7:0]  o_ovf_cnt_09,
    output logic [7:0]  o_ovf_cnt_24,
    output logic        o_busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PULL  = 2'd1;
    localparam logic [1:0] c_ST_LATCH = 2'd2;
    localparam logic [1:0] c_ST_SHIFT = 2'd3;
    localparam logic [3:0] c_burst_len = 4'(BURST_LEN);

    logic [1:0]  state_q, state_d;
    logic        ch_q, ch_d;
    logic        rr_q, rr_d;
    logic [3:0]  burst_q, burst_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  full_prev_q;
    logic [7:0]  ovf_09_q, ovf_24_q;

    logic [1:0]  w_elig;
    logic [3:0]  w_burst_inc;
    logic [31:0] w_fifo_data;

    assign w_elig      = i_ch_en & ~{i_fifo_24_empty, i_fifo_09_empty};
    assign w_burst_inc = burst_q + 4'd1;
    assign w_fifo_data = ch_q ? i_fifo_24_data : i_fifo_09_data;

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b) begin
            state_q <= c_ST_IDLE;
            ch_q    <= 1'b0;
            rr_q    <= 1'b0;
            burst_q <= 4'd0;
            idx_q   <= 2'd0;
            shreg_q <= 32'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_elig != 2'b00) begin
                    // A lone eligible channel wins outright; a tie goes to the rr pointer.
                    ch_d    = (&w_elig) ? rr_q : w_elig[1];
                    burst_d = 4'd0;
                    state_d = c_ST_PULL;
                end
            end
            c_ST_PULL: begin
                state_d = w_elig[ch_q] ? c_ST_LATCH : c_ST_IDLE;
            end
            c_ST_LATCH: begin
                shreg_d = w_fifo_data;
                idx_d   = 2'd0;
                state_d = c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                if (i_byte_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        burst_d = w_burst_inc;
                        if ((w_burst_inc < c_burst_len) && w_elig[ch_q]) begin
                            state_d = c_ST_PULL;
                        end else begin
                            rr_d    = ~ch_q;
                            state_d = c_ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_fifo_09_pull = 1'b0;
        o_fifo_24_pull = 1'b0;
        o_byte_valid   = 1'b0;
        o_byte_sow     = 1'b0;
        o_byte         = 8'h00;
        case (state_q)
            c_ST_PULL: begin
                o_fifo_09_pull = ~ch_q & w_elig[0];
                o_fifo_24_pull =  ch_q & w_elig[1];
            end
            c_ST_SHIFT: begin
                o_byte_valid = 1'b1;
                o_byte_sow   = (idx_q == 2'd0);
                case (idx_q)
                    2'd0:    o_byte = shreg_q[31:24];
                    2'd1:    o_byte = shreg_q[23:16];
                    2'd2:    o_byte = shreg_q[15:8];
                    default: o_byte = shreg_q[7:0];
                endcase
            end
            default: ;
        endcase
    end

    assign o_byte_ch = ch_q;
    assign o_busy    = (state_q != c_ST_IDLE);

    // Overflow counters run on full rising edges, independent of the scheduler.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b) begin
            full_prev_q <= 2'b00;
            ovf_09_q    <= 8'd0;
            ovf_24_q    <= 8'd0;
        end else begin
            full_prev_q <= {i_fifo_24_full, i_fifo_09_full};
            if (i_fifo_09_full && !full_prev_q[0] && i_ch_en[0] && (ovf_09_q != 8'hFF)) begin
                ovf_09_q <= ovf_09_q + 8'd1;
            end
            if (i_fifo_24_full && !full_prev_q[1] && i_ch_en[1] && (ovf_24_q != 8'hFF)) begin
                ovf_24_q <= ovf_24_q + 8'd1;
            end
        end
    end

    assign o_ovf_cnt_09 = ovf_09_q;
    assign o_ovf_cnt_24 = ovf_24_q;

endmodule
`default_nettype wire

// File: tb/tb_smi_rx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_smi_rx_scheduler: scoreboard bench with FIFO models and a word-level      |
// | arbitration reference.                                     Rev 1.0         |
// +-----------------------------------------------------------------------------+
module tb_smi_rx_scheduler;
    localparam int BURST_LEN = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [1:0]  en;
    logic        pull09, pull24;
    logic [31:0] d09, d24;
    logic        e09, e24, f09, f24;
    logic [7:0]  byte_o;
    logic        valid, ready, ch, sow, busy;
    logic [7:0]  ovf09, ovf24;

    always #5 clk = ~clk;

    smi_rx_scheduler #(.BURST_LEN(BURST_LEN)) dut (
        .i_sys_clk(clk), .i_rst_b(rst_b), .i_ch_en(en),
        .o_fifo_09_pull(pull09), .i_fifo_09_data(d09), .i_fifo_09_empty(e09), .i_fifo_09_full(f09),
        .o_fifo_24_pull(pull24), .i_fifo_24_data(d24), .i_fifo_24_empty(e24), .i_fifo_24_full(f24),
        .o_byte(byte_o), .o_byte_valid(valid), .i_byte_ready(ready), .o_byte_ch(ch),
        .o_byte_sow(sow), .o_ovf_cnt_09(ovf09), .o_ovf_cnt_24(ovf24), .o_busy(busy)
    );

    logic [31:0] q09[$];
    logic [31:0] q24[$];
    logic [9:0]  sb[$];
    bit          sb_on;
    bit          rnd_ready;
    bit          rr_m;
    int          rem09, rem24, pop09, pop24;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        p09_s, p24_s, v_s;
    logic [7:0]  b_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, then act as the FIFOs just after the rising edge.
    task automatic step();
        @(negedge clk);
        p09_s = pull09; p24_s = pull24; v_s = valid; b_s = byte_o;
        @(posedge clk);
        #1;
        if (p09_s && q09.size() > 0) begin d09 = q09.pop_front(); pop09++; end
        if (p24_s && q24.size() > 0) begin d24 = q24.pop_front(); pop24++; end
        e09 = (q09.size() == 0);
        e24 = (q24.size() == 0);
    endtask

    task automatic put_word(input bit c, input logic [31:0] w);
        if (c) q24.push_back(w); else q09.push_back(w);
        e09 = (q09.size() == 0);
        e24 = (q24.size() == 0);
    endtask

    // Reference: round-robin over whole words, bursts of up to BURST_LEN, enables static.
    task automatic predict(input logic [1:0] en_p);
        int n0, n1, i0, i1, k;
        bit c;
        logic [31:0] w;
        n0 = q09.size(); n1 = q24.size(); i0 = 0; i1 = 0;
        while ((en_p[0] && n0 > 0) || (en_p[1] && n1 > 0)) begin
            if (en_p[0] && n0 > 0 && en_p[1] && n1 > 0) c = rr_m;
            else c = !(en_p[0] && n0 > 0);
            k = 0;
            while (k < BURST_LEN && (c ? n1 : n0) > 0) begin
                if (c) begin w = q24[i1]; i1++; n1--; end
                else   begin w = q09[i0]; i0++; n0--; end
                for (int b = 0; b < 4; b++) sb.push_back({c, (b == 0), w[31-8*b -: 8]});
                k++;
            end
            rr_m = !c;
        end
        rem09 = n0; rem24 = n1;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || busy) && cyc < 4000) begin
            step();
            if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("drain_in_budget", 64'(cyc < 4000), 1);
        ready = 1'b1;
        step(); step();
        chk("remaining_09", q09.size(), rem09);
        chk("remaining_24", q24.size(), rem24);
        chk("idle_after_drain", busy, 0);
    endtask

    // Monitor: scoreboard pops, backpressure hold and pull legality.
    logic       stall_q = 1'b0;
    logic [9:0] held_q  = '0;
    always @(negedge clk) begin
        if (pull09) begin
            chk("pull09_while_empty", e09, 0);
            chk("pulls_exclusive", pull24, 0);
        end
        if (pull24) chk("pull24_while_empty", e24, 0);
        if (stall_q && rst_b) begin
            chk("hold_valid", valid, 1);
            chk("hold_byte_tags", {ch, sow, byte_o}, held_q);
        end
        if (valid && ready && sb_on) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL extra_byte: actual=0x%0h required=none", {ch, sow, byte_o});
            end else begin
                chk("byte_ch_sow_data", {ch, sow, byte_o}, sb.pop_front());
            end
        end
        stall_q = rst_b && valid && !ready;
        held_q  = {ch, sow, byte_o};
    end

    int          e_o09, e_o24;
    logic        pf09, pf24;
    task automatic ovf_cycle(input logic nf09, input logic nf24, input logic [1:0] nen);
        f09 = nf09; f24 = nf24; en = nen;
        if (nf09 && !pf09 && nen[0] && e_o09 < 255) e_o09++;
        if (nf24 && !pf24 && nen[1] && e_o24 < 255) e_o24++;
        pf09 = nf09; pf24 = nf24;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  vpat9;
        logic [11:0] vpat12;
        rst_b = 1'b0; en = 2'b00; ready = 1'b1; f09 = 1'b0; f24 = 1'b0;
        d09 = '0; d24 = '0; e09 = 1'b1; e24 = 1'b1;
        sb_on = 1'b1; rnd_ready = 1'b0; rr_m = 1'b0; pop09 = 0; pop24 = 0;

        // Reset held with both FIFOs non-empty.
        put_word(0, 32'hCAFE0001);
        put_word(1, 32'hBEEF0002);
        en = 2'b11;
        step(); step(); step();
        chk("rst_outputs", {pull09, pull24, valid, byte_o, ch, sow, busy}, 0);
        chk("rst_counters", {ovf09, ovf24}, 0);
        predict(2'b11);
        rst_b = 1'b1;
        step();
        chk("first_pull_not_yet", {p09_s, p24_s}, 2'b00);
        step();
        chk("first_pull_is_09", {p09_s, p24_s}, 2'b10);
        drain();

        // Single word: latency and byte window.
        en = 2'b00; pop09 = 0;
        put_word(0, 32'h5AC3E7F1);
        predict(2'b01);
        en = 2'b01;
        for (int i = 0; i < 9; i++) begin step(); vpat9[8-i] = v_s; end
        chk("single_valid_window", vpat9, 9'b000111100);
        drain();
        chk("single_one_pull", pop09, 1);

        // Backpressure on byte 1 for three cycles.
        en = 2'b00; pop09 = 0;
        put_word(0, 32'h5AC3E7F1);
        predict(2'b01);
        en = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            step();
            vpat12[12-i] = v_s;
            if (i >= 5 && i <= 8) chk("bp_byte1_held", b_s, 8'hC3);
            if (i == 4) ready = 1'b0;
            if (i == 7) ready = 1'b1;
        end
        chk("bp_valid_window", vpat12, 12'b000111111100);
        drain();
        chk("bp_one_pull", pop09, 1);

        // Round-robin bursts over two 10-word FIFOs.
        en = 2'b00; pop09 = 0; pop24 = 0;
        for (int i = 0; i < 10; i++) begin
            put_word(0, $urandom);
            put_word(1, $urandom);
        end
        predict(2'b11);
        en = 2'b11;
        drain();
        chk("rr_pulls_09", pop09, 10);
        chk("rr_pulls_24", pop24, 10);

        // Randomised loads, enables and backpressure.
        rnd_ready = 1'b1;
        for (int it = 0; it < 8; it++) begin
            en = 2'b00;
            for (int i = $urandom_range(0, 9); i > 0; i--) put_word(0, $urandom);
            for (int i = $urandom_range(0, 9); i > 0; i--) put_word(1, $urandom);
            en = 2'($urandom_range(0, 3));
            predict(en);
            drain();
        end
        rnd_ready = 1'b0;

        // Reset in the middle of a word.
        en = 2'b00;
        q09.delete(); q24.delete();
        put_word(0, 32'hA5A5A500);
        put_word(0, 32'h11223344);
        sb_on = 1'b0;
        en = 2'b01;
        for (int i = 0; i < 5; i++) step();
        chk("midword_valid_before_reset", valid, 1);
        rst_b = 1'b0;
        step();
        chk("midword_valid_dropped", {valid, busy}, 2'b00);
        rr_m = 1'b0;
        predict(2'b01);
        sb_on = 1'b1;
        rst_b = 1'b1;
        drain();

        // Overflow counters.
        en = 2'b00; pf09 = 1'b0; pf24 = 1'b0; e_o09 = 0; e_o24 = 0;
        step();
        for (int i = 0; i < 300; i++) begin
            ovf_cycle(0, 1, 2'b10);
            ovf_cycle(0, 0, 2'b10);
            if (i == 9) chk("ovf24_after_10", ovf24, 10);
        end
        chk("ovf24_saturated", ovf24, 255);
        chk("ovf09_untouched", ovf09, 0);
        for (int i = 0; i < 5; i++) begin
            ovf_cycle(0, 1, 2'b00);
            ovf_cycle(0, 0, 2'b00);
        end
        chk("ovf24_disabled_hold", ovf24, 255);
        for (int i = 0; i < 4; i++) ovf_cycle(1, 0, 2'b01);
        chk("ovf09_level_counts_once", ovf09, 1);
        for (int i = 0; i < 200; i++) begin
            ovf_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            chk("ovf09_random", ovf09, e_o09);
        end
        chk("ovf24_random_end", ovf24, e_o24);

        step(); step();
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/smi_rx_scheduler.md
# smi_rx_scheduler

Read-side scheduler that shares the single SMI byte path between the two LVDS RX sample FIFOs (0.9 GHz and 2.4 GHz channels). It arbitrates round-robin between enabled, non-empty FIFOs and pulls 32-bit I/Q words in bursts. Each word is serialized MSB-first into tagged bytes for the SMI controller, over a valid/ready handshake. It also maintains per-channel overflow counters that the host reads through the SPI register map.

## Interface
- BURST_LEN, 4: maximum words taken from one channel per grant before the arbiter re-evaluates (1..15)
- i_sys_clk  in  1  system clock; FIFO read side and SMI controller share it
- i_rst_b  in  1  synchronous reset, active low
- i_ch_en  in  2  channel enable; [0]=09, [1]=24
- o_fifo_09_pull  out  1  one-cycle read strobe to 09 FIFO
- i_fifo_09_data  in  32  09 FIFO read data, valid the cycle after pull
- i_fifo_09_empty  in  1  09 FIFO empty
- i_fifo_09_full  in  1  09 FIFO full
- o_fifo_24_pull, i_fifo_24_data, i_fifo_24_empty, i_fifo_24_full: same for 24 channel
- o_byte  out  8  byte to SMI controller
- o_byte_valid  out  1  o_byte/o_byte_ch/o_byte_sow valid
- i_byte_ready  in  1  SMI controller accepts byte when valid&ready
- o_byte_ch  out  1  source channel of o_byte; 0=09, 1=24
- o_byte_sow  out  1  high on byte 0 (bits 31:24) of each word
- o_ovf_cnt_09  out  8  saturating count of 09 FIFO full events
- o_ovf_cnt_24  out  8  same for 24
- o_busy  out  1  state != IDLE

## Operation
- Reset (i_rst_b low at clock edge): state=IDLE, all pulls 0, o_byte=0, o_byte_valid=0, o_byte_ch=0, o_byte_sow=0, both counters 0, rr pointer=0 (09 first), burst count=0, o_busy=0. A partially shifted word is discarded.
- Eligibility: elig[c] = i_ch_en[c] & !empty[c].
- IDLE: if no channel is eligible, stay. If only one channel is eligible, grant it. If both are eligible, grant the channel at the rr pointer. Latch the grant into o_byte_ch, clear burst count, go to PULL.
- PULL: assert the granted channel's pull for exactly one cycle, go to LATCH. Never pull when that FIFO is empty; eligibility is re-checked in PULL, and if it fails, go to IDLE without pulling.
- LATCH: capture 32-bit data into the shift register, go to SHIFT with byte index 0.
- SHIFT: o_byte = shreg[31:24 - 8*idx], o_byte_valid=1, o_byte_sow=(idx==0). On valid&ready, idx++. o_byte and its tags hold stable while valid&!ready.
- Word end (byte 3 accepted):
  - burst count++.
  - If burst count < BURST_LEN and the same channel is still eligible, go to PULL.
  - Otherwise, set rr pointer = other channel and go to IDLE.
- Disabling a channel mid-word: the current word completes; the enable is checked only at word end.
- Overflow counters: increment on the rising edge of full[c] (registered previous value) while i_ch_en[c]=1. Saturate at 255. Independent of the FSM. Cleared only by reset.
- Pull strobes are mutually exclusive, and never both high.

## Timing
- Empty→first byte: elig seen in IDLE at cycle N; pull at N+1; capture at N+2; o_byte_valid at N+3.
- With ready tied high, one word takes 4 SHIFT cycles, plus 2 cycles (PULL, LATCH) between words of a burst. Steady state is 6 cycles/word.
- Channel switch costs 1 extra IDLE cycle.
- o_byte_valid deasserts the cycle after byte 3 is accepted and stays low for at least 2 cycles.
- Overflow counter updates 1 cycle after the rising edge of full.

## Test plan
- Reset: hold i_rst_b=0 with both FIFOs non-empty → all outputs 0, no pulls. Release → first pull is o_fifo_09_pull at cycle 2 after release.
- Single word: 09 FIFO holds 0x5AC3E7F1, ready=1, en=2'b01 → bytes 5A,C3,E7,F1 on cycles N+3..N+6. o_byte_sow only on 5A, o_byte_ch=0, exactly one pull.
- Backpressure: ready low for 3 cycles on byte 1 → C3 held stable with valid=1, no extra pull, 4 bytes total delivered in order.
- Round-robin burst: both FIFOs hold 10 words, BURST_LEN=4, ready=1 → channel sequence 09×4, 24×4, 09×4, 24×4, 09×2, 24×2 (20 words, 80 bytes), with no pull while empty.
- Overflow: pulse i_fifo_24_full 300 times with en[1]=1 → o_ovf_cnt_24=255. Same pulses with en[1]=0 → counter unchanged.
- Reset mid-word: assert reset after byte 1 of 0xA5A5A500 → valid drops next edge. After release, the next byte seen is byte 0 of the following word, with o_byte_sow=1.
